// File: rtl/uart_bm_pkg.sv
// Shared types and protocol constants for the UART bus master bridge.
package uart_bm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

endpackage

// File: rtl/uart_bus_master_if.sv
// Bus-initiator signal group shared by the CPU data bus and the UART bridge.
interface uart_bus_master_if;

    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output bus_rd, output bus_wr, output addr, output wdata, input rdata);
    modport slave  (input bus_rd, input bus_wr, input addr, input wdata, output rdata);

endinterface

// File: rtl/uart_byte_io.sv
// 8N1 byte transceiver: input synchronizer, mid-bit sampling deserializer, serializer.
module uart_byte_io
    import uart_bm_pkg::*;
#(
    parameter int unsigned DIV = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bits;
    logic [7:0]      rx_sh;

    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_nbits;
    logic [8:0]      tx_sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_err   <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at half a bit is a glitch.
                    if (rx_cnt == HALF_END) begin
                        rx_cnt  <= '0;
                        rx_bits <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        if (rx_bits == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bits <= rx_bits + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_sh;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // tx_sh holds the stop bit above the data so one right shift walks all ten bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_nbits <= '0;
            tx_sh    <= '1;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                tx_cnt   <= '0;
                tx_nbits <= '0;
                tx_sh    <= {1'b1, tx_data};
            end
        end else if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_nbits == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                tx       <= tx_sh[0];
                tx_sh    <= {1'b1, tx_sh[8:1]};
                tx_nbits <= tx_nbits + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART command-frame decoder that issues 32-bit reads/writes as a bus initiator.
module uart_bus_master #(
    parameter int unsigned DIV          = 10417,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              halt,
    uart_bus_master_if.master bus
);

    import uart_bm_pkg::*;

    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * DIV;
    localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);
    localparam logic [TW-1:0] TMO_END = TW'(TMO_LIMIT);

    logic          rx_valid, rx_err, tx_start, tx_busy;
    logic [7:0]    rx_data, tx_data;
    state_t        state;
    logic          is_wr, rd_second;
    logic [1:0]    byte_cnt;
    logic [2:0]    rsp_left;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   field_sh, field_next, rsp_sh, addr_q, wdata_q;
    logic          bus_rd_q, bus_wr_q;

    uart_byte_io #(.DIV(DIV)) u_io (
        .clk      (clk),
        .reset    (reset),
        .rx       (uart_rx),
        .tx       (uart_tx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_err   (rx_err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    assign field_next = {field_sh[23:0], rx_data};
    assign bus.bus_rd = bus_rd_q;
    assign bus.bus_wr = bus_wr_q;
    assign bus.addr   = addr_q;
    assign bus.wdata  = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            halt      <= 1'b0;
            is_wr     <= 1'b0;
            rd_second <= 1'b0;
            byte_cnt  <= '0;
            rsp_left  <= '0;
            tmo_cnt   <= '0;
            field_sh  <= '0;
            rsp_sh    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus_rd_q  <= 1'b0;
            bus_wr_q  <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            is_wr <= (rx_data == CMD_WR);
                            halt  <= 1'b1;
                            state <= ST_ADDR;
                        end else begin
                            rsp_sh   <= {RSP_ERR, 24'h0};
                            rsp_left <= 3'd1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_ADDR, ST_DATA: begin
                    // Abort takes priority over a byte landing in the same cycle.
                    if (rx_err || tmo_cnt == TMO_END) begin
                        halt  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (rx_valid) begin
                        tmo_cnt  <= '0;
                        field_sh <= field_next;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            if (state == ST_DATA) begin
                                wdata_q  <= field_next;
                                bus_wr_q <= 1'b1;
                                state    <= ST_BUS_WR;
                            end else begin
                                addr_q <= field_next;
                                if (is_wr) begin
                                    state <= ST_DATA;
                                end else begin
                                    bus_rd_q  <= 1'b1;
                                    rd_second <= 1'b0;
                                    state     <= ST_BUS_RD;
                                end
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_BUS_WR: begin
                    bus_wr_q <= 1'b0;
                    rsp_sh   <= {RSP_ACK, 24'h0};
                    rsp_left <= 3'd1;
                    state    <= ST_RESP;
                end
                ST_BUS_RD: begin
                    if (!rd_second) begin
                        rd_second <= 1'b1;
                    end else begin
                        bus_rd_q <= 1'b0;
                        rsp_sh   <= bus.rdata;
                        rsp_left <= 3'd4;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // tx_busy lags tx_start by a cycle, so wait out the pulse too.
                    if (!tx_start && !tx_busy) begin
                        if (rsp_left != 3'd0) begin
                            tx_start <= 1'b1;
                            tx_data  <= rsp_sh[31:24];
                            rsp_sh   <= {rsp_sh[23:0], 8'h00};
                            rsp_left <= rsp_left - 1'b1;
                        end else begin
                            halt  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench: host-side UART model, bus monitor and frame-level reference model.
module tb_uart_bus_master;

    localparam int unsigned DIV   = 16;
    localparam int unsigned TBITS = 20;

    typedef byte unsigned bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx, halt;
    logic [31:0] rd_value = 32'h0;

    uart_bus_master_if bus();

    uart_bus_master #(.DIV(DIV), .TIMEOUT_BITS(TBITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .halt    (halt),
        .bus     (bus.master)
    );

    assign bus.rdata = rd_value;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    byte unsigned tx_log[$];
    logic         halt_log[$];
    int           wr_pulses = 0, rd_cycles = 0, halt_cycles = 0;
    logic [31:0]  wr_addr = '0, wr_data = '0, rd_addr = '0;

    // Host-side receiver: decodes uart_tx, recording halt at each stop-bit sample.
    initial begin : tx_decoder
        byte unsigned b;
        forever begin
            @(negedge uart_tx);
            repeat (DIV / 2) @(negedge clk);
            if (uart_tx == 1'b0 && reset) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (DIV) @(negedge clk);
                if (uart_tx) begin
                    tx_log.push_back(b);
                    halt_log.push_back(halt);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (bus.bus_wr) begin
                wr_pulses++;
                wr_addr = bus.addr;
                wr_data = bus.wdata;
            end
            if (bus.bus_rd) begin
                rd_cycles++;
                rd_addr = bus.addr;
            end
            if (halt) halt_cycles++;
        end
    end

    // Reference model: what a frame should do on the bus and send back.
    function automatic void model(input bq_t fr, input logic [31:0] rd, output bq_t rsp,
                                  output int n_wr, output int n_rdc,
                                  output logic [31:0] a, output logic [31:0] d);
        rsp = {};
        n_wr = 0;
        n_rdc = 0;
        a = '0;
        d = '0;
        if (fr[0] == 8'h57 || fr[0] == 8'h52) a = {fr[1], fr[2], fr[3], fr[4]};
        if (fr[0] == 8'h57) begin
            d = {fr[5], fr[6], fr[7], fr[8]};
            n_wr = 1;
            rsp.push_back(8'h4B);
        end else if (fr[0] == 8'h52) begin
            n_rdc = 2;
            for (int i = 3; i >= 0; i--) rsp.push_back(rd[8*i +: 8]);
        end else begin
            rsp.push_back(8'h3F);
        end
    endfunction

    function automatic bq_t mk_frame(input byte unsigned cmd, input logic [31:0] a, input logic [31:0] d);
        bq_t f;
        f.push_back(cmd);
        if (cmd == 8'h57 || cmd == 8'h52)
            for (int i = 3; i >= 0; i--) f.push_back(a[8*i +: 8]);
        if (cmd == 8'h57)
            for (int i = 3; i >= 0; i--) f.push_back(d[8*i +: 8]);
        return f;
    endfunction

    task automatic send_byte(input byte unsigned b, input bit stop_ok);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop_ok) repeat (DIV) @(negedge clk);
    endtask

    task automatic send_frame(input bq_t fr);
        foreach (fr[i]) send_byte(fr[i], 1'b1);
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int n = 0;
        while (tx_log.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_halt_low();
        int n = 0;
        while (halt && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (uart_tx !== 1'b1)      begin fails++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        checks++; if (halt !== 1'b0)         begin fails++; $display("FAIL reset_halt got=%b exp=0", halt); end
        checks++; if (bus.bus_rd !== 1'b0)   begin fails++; $display("FAIL reset_rd got=%b exp=0", bus.bus_rd); end
        checks++; if (bus.bus_wr !== 1'b0)   begin fails++; $display("FAIL reset_wr got=%b exp=0", bus.bus_wr); end
        checks++; if (bus.addr !== 32'h0)    begin fails++; $display("FAIL reset_addr got=%h exp=0", bus.addr); end
        checks++; if (bus.wdata !== 32'h0)   begin fails++; $display("FAIL reset_wdata got=%h exp=0", bus.wdata); end
        reset = 1'b1;
        repeat (4 * DIV) @(negedge clk);
    endtask

    task automatic test_write();
        for (int k = 0; k < 4; k++) begin
            bq_t fr, rsp;
            int n_wr, n_rdc, b_tx, b_wr, b_rd;
            logic [31:0] ea, ed;
            fr = (k == 0) ? mk_frame(8'h57, 32'h4000000C, 32'h000000A5)
                          : mk_frame(8'h57, $urandom, $urandom);
            model(fr, rd_value, rsp, n_wr, n_rdc, ea, ed);
            b_tx = tx_log.size(); b_wr = wr_pulses; b_rd = rd_cycles;
            send_byte(fr[0], 1'b1);
            checks++; if (halt !== 1'b1) begin fails++; $display("FAIL wr_halt_rise got=%b exp=1", halt); end
            for (int i = 1; i < fr.size(); i++) send_byte(fr[i], 1'b1);
            wait_bytes(b_tx + rsp.size(), 14 * DIV);
            checks++;
            if (tx_log.size() != b_tx + rsp.size() || tx_log[b_tx] !== rsp[0]) begin
                fails++; $display("FAIL wr_resp got=%h (n=%0d) exp=%h", tx_log[tx_log.size()-1], tx_log.size() - b_tx, rsp[0]);
            end
            checks++; if (halt_log[halt_log.size()-1] !== 1'b1) begin fails++; $display("FAIL wr_halt_during_resp got=0 exp=1"); end
            checks++; if (wr_pulses - b_wr != n_wr) begin fails++; $display("FAIL wr_pulses got=%0d exp=%0d", wr_pulses - b_wr, n_wr); end
            checks++; if (wr_addr !== ea) begin fails++; $display("FAIL wr_addr got=%h exp=%h", wr_addr, ea); end
            checks++; if (wr_data !== ed) begin fails++; $display("FAIL wr_data got=%h exp=%h", wr_data, ed); end
            checks++; if (rd_cycles - b_rd != n_rdc) begin fails++; $display("FAIL wr_no_read got=%0d exp=%0d", rd_cycles - b_rd, n_rdc); end
            wait_halt_low();
            checks++; if (halt !== 1'b0) begin fails++; $display("FAIL wr_halt_fall got=%b exp=0", halt); end
        end
    endtask

    task automatic test_read();
        for (int k = 0; k < 4; k++) begin
            bq_t fr, rsp;
            int n_wr, n_rdc, b_tx, b_wr, b_rd;
            logic [31:0] ea, ed;
            rd_value = (k == 0) ? 32'h12345678 : $urandom;
            fr = (k == 0) ? mk_frame(8'h52, 32'h40000014, '0) : mk_frame(8'h52, $urandom, '0);
            model(fr, rd_value, rsp, n_wr, n_rdc, ea, ed);
            b_tx = tx_log.size(); b_wr = wr_pulses; b_rd = rd_cycles;
            send_frame(fr);
            wait_bytes(b_tx + rsp.size(), 50 * DIV);
            checks++; if (tx_log.size() != b_tx + 4) begin fails++; $display("FAIL rd_resp_count got=%0d exp=4", tx_log.size() - b_tx); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tx_log.size() <= b_tx + i || tx_log[b_tx + i] !== rsp[i]) begin
                    fails++; $display("FAIL rd_resp_byte%0d got=%h exp=%h", i, (tx_log.size() > b_tx + i) ? tx_log[b_tx + i] : 8'hxx, rsp[i]);
                end
            end
            checks++; if (rd_cycles - b_rd != n_rdc) begin fails++; $display("FAIL rd_cycles got=%0d exp=%0d", rd_cycles - b_rd, n_rdc); end
            checks++; if (rd_addr !== ea) begin fails++; $display("FAIL rd_addr got=%h exp=%h", rd_addr, ea); end
            checks++; if (wr_pulses != b_wr) begin fails++; $display("FAIL rd_no_write got=%0d exp=0", wr_pulses - b_wr); end
            checks++; if (halt_log[halt_log.size()-1] !== 1'b1) begin fails++; $display("FAIL rd_halt_last_byte got=0 exp=1"); end
            wait_halt_low();
            checks++; if (halt !== 1'b0) begin fails++; $display("FAIL rd_halt_fall got=%b exp=0", halt); end
        end
    endtask

    task automatic test_bad_cmd();
        for (int k = 0; k < 3; k++) begin
            byte unsigned c;
            int b_tx, b_wr, b_rd, b_h;
            c = (k == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            while (c == 8'h57 || c == 8'h52) c = 8'($urandom_range(0, 255));
            b_tx = tx_log.size(); b_wr = wr_pulses; b_rd = rd_cycles; b_h = halt_cycles;
            send_byte(c, 1'b1);
            wait_bytes(b_tx + 1, 14 * DIV);
            repeat (2 * DIV) @(negedge clk);
            checks++;
            if (tx_log.size() != b_tx + 1 || tx_log[b_tx] !== 8'h3F) begin
                fails++; $display("FAIL bad_resp cmd=%h got=%h (n=%0d) exp=3f", c, tx_log[tx_log.size()-1], tx_log.size() - b_tx);
            end
            checks++; if (halt_cycles != b_h) begin fails++; $display("FAIL bad_halt got=%0d cycles exp=0", halt_cycles - b_h); end
            checks++; if (wr_pulses + rd_cycles != b_wr + b_rd) begin fails++; $display("FAIL bad_bus got=%0d exp=0", wr_pulses + rd_cycles - b_wr - b_rd); end
        end
    endtask

    task automatic test_timeout();
        bq_t fr, rsp;
        int n_wr, n_rdc, b_tx, b_wr, b_rd;
        logic [31:0] ea, ed;
        b_tx = tx_log.size(); b_wr = wr_pulses; b_rd = rd_cycles;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TBITS * DIV - 40) @(negedge clk);
        checks++; if (halt !== 1'b1) begin fails++; $display("FAIL tmo_early got=%b exp=1", halt); end
        repeat (80) @(negedge clk);
        checks++; if (halt !== 1'b0) begin fails++; $display("FAIL tmo_halt got=%b exp=0", halt); end
        checks++; if (tx_log.size() != b_tx) begin fails++; $display("FAIL tmo_resp got=%0d exp=0", tx_log.size() - b_tx); end
        checks++; if (wr_pulses + rd_cycles != b_wr + b_rd) begin fails++; $display("FAIL tmo_bus got=%0d exp=0", wr_pulses + rd_cycles - b_wr - b_rd); end
        rd_value = $urandom;
        fr = mk_frame(8'h52, $urandom, '0);
        model(fr, rd_value, rsp, n_wr, n_rdc, ea, ed);
        b_tx = tx_log.size();
        send_frame(fr);
        wait_bytes(b_tx + 4, 50 * DIV);
        checks++;
        if (tx_log.size() != b_tx + 4 || {tx_log[b_tx], tx_log[b_tx+1], tx_log[b_tx+2], tx_log[b_tx+3]} !== rd_value) begin
            fails++; $display("FAIL tmo_recover_read got_n=%0d exp=%h", tx_log.size() - b_tx, rd_value);
        end
        checks++; if (rd_addr !== ea) begin fails++; $display("FAIL tmo_recover_addr got=%h exp=%h", rd_addr, ea); end
        wait_halt_low();
    endtask

    task automatic test_framing();
        int b_tx, b_wr, b_rd;
        b_tx = tx_log.size(); b_wr = wr_pulses; b_rd = rd_cycles;
        send_byte(8'h52, 1'b1);
        checks++; if (halt !== 1'b1) begin fails++; $display("FAIL frm_halt_rise got=%b exp=1", halt); end
        send_byte(8'($urandom), 1'b0);
        repeat (12 * DIV) @(negedge clk);
        checks++; if (halt !== 1'b0) begin fails++; $display("FAIL frm_halt got=%b exp=0", halt); end
        checks++; if (tx_log.size() != b_tx) begin fails++; $display("FAIL frm_resp got=%0d exp=0", tx_log.size() - b_tx); end
        checks++; if (wr_pulses + rd_cycles != b_wr + b_rd) begin fails++; $display("FAIL frm_bus got=%0d exp=0", wr_pulses + rd_cycles - b_wr - b_rd); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            bq_t fr, rsp;
            int n_wr, n_rdc, b_tx, b_wr, b_rd, sel;
            logic [31:0] ea, ed;
            sel = $urandom_range(0, 2);
            rd_value = $urandom;
            fr = mk_frame((sel == 0) ? 8'h57 : (sel == 1) ? 8'h52 : 8'h00, $urandom, $urandom);
            model(fr, rd_value, rsp, n_wr, n_rdc, ea, ed);
            b_tx = tx_log.size(); b_wr = wr_pulses; b_rd = rd_cycles;
            send_frame(fr);
            wait_bytes(b_tx + rsp.size(), 50 * DIV);
            wait_halt_low();
            checks++;
            if (tx_log.size() != b_tx + rsp.size()) begin
                fails++; $display("FAIL b2b_count cmd=%h got=%0d exp=%0d", fr[0], tx_log.size() - b_tx, rsp.size());
            end else begin
                for (int i = 0; i < rsp.size(); i++)
                    if (tx_log[b_tx + i] !== rsp[i]) begin
                        fails++; $display("FAIL b2b_byte%0d cmd=%h got=%h exp=%h", i, fr[0], tx_log[b_tx + i], rsp[i]);
                        break;
                    end
            end
            checks++;
            if (wr_pulses - b_wr != n_wr || rd_cycles - b_rd != n_rdc) begin
                fails++; $display("FAIL b2b_bus cmd=%h got_wr=%0d got_rd=%0d exp_wr=%0d exp_rd=%0d", fr[0], wr_pulses - b_wr, rd_cycles - b_rd, n_wr, n_rdc);
            end
        end
    endtask

    task automatic test_reset_mid();
        bq_t fr, rsp;
        int n_wr, n_rdc, b_tx, n;
        logic [31:0] ea, ed;
        rd_value = $urandom;
        b_tx = tx_log.size();
        send_frame(mk_frame(8'h52, $urandom, '0));
        wait_bytes(b_tx + 1, 20 * DIV);
        n = 0;
        while (uart_tx !== 1'b0 && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        checks++; if (uart_tx !== 1'b0 || halt !== 1'b1) begin fails++; $display("FAIL rstmid_second_byte tx=%b halt=%b exp tx=0 halt=1", uart_tx, halt); end
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx got=%b exp=1", uart_tx); end
        checks++; if (halt !== 1'b0)    begin fails++; $display("FAIL rstmid_halt got=%b exp=0", halt); end
        checks++; if (bus.addr !== 32'h0) begin fails++; $display("FAIL rstmid_addr got=%h exp=0", bus.addr); end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        fr = mk_frame(8'h57, $urandom, $urandom);
        model(fr, rd_value, rsp, n_wr, n_rdc, ea, ed);
        b_tx = tx_log.size();
        send_frame(fr);
        wait_bytes(b_tx + 1, 14 * DIV);
        checks++;
        if (tx_log.size() != b_tx + 1 || tx_log[b_tx] !== 8'h4B) begin
            fails++; $display("FAIL rstmid_recover_resp got_n=%0d exp=4b", tx_log.size() - b_tx);
        end
        checks++; if (wr_addr !== ea || wr_data !== ed) begin fails++; $display("FAIL rstmid_recover_bus got=%h/%h exp=%h/%h", wr_addr, wr_data, ea, ed); end
        wait_halt_low();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_timeout();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
